// File: rtl/noc_packetizer.sv
// noc_packetizer: PE-side NoC transmitter that turns a (dest, len, payload) request into a
// header/body/tail flit stream. Defining NOC_PKT_CRC_EN appends an XOR checksum tail flit.
module noc_packetizer #(
   parameter int         DATA_WIDTH = 32,
   parameter logic [3:0] SRC_X      = 4'd0,
   parameter logic [3:0] SRC_Y      = 4'd0
) (
   input  logic                  noc_clk,
   input  logic                  noc_rst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [3:0]            cmd_dest_x,
   input  logic [3:0]            cmd_dest_y,
   input  logic [3:0]            cmd_len,
   input  logic                  data_valid,
   output logic                  data_ready,
   input  logic [DATA_WIDTH-1:0] data,
   output logic                  flit_valid,
   input  logic                  flit_ready,
   output logic [DATA_WIDTH-1:0] flit,
   input  logic                  VCready,
   output logic                  is_header,
   output logic                  is_tail
);

`ifdef NOC_PKT_CRC_EN
   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_HEAD = 2'd1, ST_BODY = 2'd2, ST_CSUM = 2'd3} state_t;
`else
   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_HEAD = 2'd1, ST_BODY = 2'd2} state_t;
`endif

   function automatic logic [DATA_WIDTH-1:0] make_header(input logic [3:0] dx,
                                                         input logic [3:0] dy,
                                                         input logic [3:0] ln);
      logic [DATA_WIDTH-1:0] h;
      h = {DATA_WIDTH{1'b0}};
      h[DATA_WIDTH-1 -: 20] = {dx, dy, SRC_X, SRC_Y, ln};
      return h;
   endfunction

`ifdef NOC_PKT_CRC_EN
   function automatic logic [DATA_WIDTH-1:0] csum_fold(input logic [DATA_WIDTH-1:0] acc,
                                                       input logic [DATA_WIDTH-1:0] word);
      return acc ^ word;
   endfunction
`endif

   state_t                state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic [3:0]            len_q, len_d;
   logic [3:0]            dest_x_q, dest_x_d;
   logic [3:0]            dest_y_q, dest_y_d;
   logic [DATA_WIDTH-1:0] flit_q, flit_d;
   logic                  is_header_q, is_header_d;
   logic                  is_tail_q, is_tail_d;
   logic                  flit_valid_q, flit_valid_d;
`ifdef NOC_PKT_CRC_EN
   logic [DATA_WIDTH-1:0] csum_q, csum_d;
`endif
   logic                  fire_s;
   logic                  can_load_s;
   logic                  cmd_ready_s;
   logic                  data_ready_s;

   assign fire_s     = flit_valid_q & flit_ready;
   assign can_load_s = ~flit_valid_q | flit_ready;
   assign cmd_ready  = cmd_ready_s & ~noc_rst;
   assign data_ready = data_ready_s & ~noc_rst;
   assign flit       = flit_q;
   assign is_header  = is_header_q;
   assign is_tail    = is_tail_q;
   assign flit_valid = flit_valid_q;

   // Next-state, handshake and output-stage load logic
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      len_d        = len_q;
      dest_x_d     = dest_x_q;
      dest_y_d     = dest_y_q;
      flit_d       = flit_q;
      is_header_d  = is_header_q;
      is_tail_d    = is_tail_q;
      cmd_ready_s  = 1'b0;
      data_ready_s = 1'b0;
`ifdef NOC_PKT_CRC_EN
      csum_d       = csum_q;
`endif
      if (fire_s) begin
         flit_valid_d = 1'b0;
      end else begin
         flit_valid_d = flit_valid_q;
      end

      case (state_q)
         ST_IDLE: begin
            cmd_ready_s = 1'b1;
            if (cmd_valid) begin
               dest_x_d = cmd_dest_x;
               dest_y_d = cmd_dest_y;
               len_d    = cmd_len;
               cnt_d    = 4'd0;
               state_d  = ST_HEAD;
            end else begin
               state_d  = ST_IDLE;
            end
         end
         ST_HEAD: begin
            // Stage is empty on entry, so a valid flit here is our header; VCready no longer matters
            if (flit_valid_q) begin
               if (fire_s) begin
`ifdef NOC_PKT_CRC_EN
                  state_d = (len_q == 4'd0) ? ST_CSUM : ST_BODY;
`else
                  state_d = (len_q == 4'd0) ? ST_IDLE : ST_BODY;
`endif
               end else begin
                  state_d = ST_HEAD;
               end
            end else if (VCready) begin
               flit_d       = make_header(dest_x_q, dest_y_q, len_q);
               is_header_d  = 1'b1;
               flit_valid_d = 1'b1;
`ifdef NOC_PKT_CRC_EN
               is_tail_d    = 1'b0;
               csum_d       = make_header(dest_x_q, dest_y_q, len_q);
`else
               is_tail_d    = (len_q == 4'd0);
`endif
            end else begin
               state_d = ST_HEAD;
            end
         end
         ST_BODY: begin
            if (cnt_q != len_q) begin
               data_ready_s = can_load_s;
               if (can_load_s && data_valid) begin
                  flit_d       = data;
                  is_header_d  = 1'b0;
                  flit_valid_d = 1'b1;
                  cnt_d        = cnt_q + 4'd1;
`ifdef NOC_PKT_CRC_EN
                  is_tail_d    = 1'b0;
                  csum_d       = csum_fold(csum_q, data);
`else
                  is_tail_d    = (cnt_q == len_q - 4'd1);
`endif
               end else begin
                  cnt_d = cnt_q;
               end
            end else begin
`ifdef NOC_PKT_CRC_EN
               state_d = ST_CSUM;
`else
               if (fire_s) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_BODY;
               end
`endif
            end
         end
`ifdef NOC_PKT_CRC_EN
         ST_CSUM: begin
            // Only the checksum flit ever carries is_tail in this build
            if (flit_valid_q && is_tail_q) begin
               if (fire_s) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_CSUM;
               end
            end else if (can_load_s) begin
               flit_d       = csum_q;
               is_header_d  = 1'b0;
               is_tail_d    = 1'b1;
               flit_valid_d = 1'b1;
            end else begin
               state_d = ST_CSUM;
            end
         end
`endif
         default: begin
            state_d      = ST_IDLE;
            flit_valid_d = 1'b0;
         end
      endcase
   end

   // State, packet context and output-stage registers
   always_ff @(posedge noc_clk) begin
      if (noc_rst) begin
         state_q      <= ST_IDLE;
         cnt_q        <= 4'd0;
         len_q        <= 4'd0;
         dest_x_q     <= 4'd0;
         dest_y_q     <= 4'd0;
         flit_q       <= {DATA_WIDTH{1'b0}};
         is_header_q  <= 1'b0;
         is_tail_q    <= 1'b0;
         flit_valid_q <= 1'b0;
`ifdef NOC_PKT_CRC_EN
         csum_q       <= {DATA_WIDTH{1'b0}};
`endif
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         len_q        <= len_d;
         dest_x_q     <= dest_x_d;
         dest_y_q     <= dest_y_d;
         flit_q       <= flit_d;
         is_header_q  <= is_header_d;
         is_tail_q    <= is_tail_d;
         flit_valid_q <= flit_valid_d;
`ifdef NOC_PKT_CRC_EN
         csum_q       <= csum_d;
`endif
      end
   end

endmodule

// File: doc/noc_packetizer.md
# noc_packetizer

Local-side network-interface transmitter that turns a (destination, length, payload) message from a processing element into a header/body/tail flit stream and drives one router receive port of the NoC fabric, i.e. the `valid/ready/flit/VCready/is_header/is_tail` channel that the fabric consumes. It is the source end of the same flit protocol the fabric's receive ports implement. It sits between a PE and its router's local input channel. One packet is in flight at a time.

## Interface
- `DATA_WIDTH`, default 32: flit width (matches `Noc_Data_Width`); must be >= 20.
- `SRC_X`, default 0: local node X coordinate, 4 bits.
- `SRC_Y`, default 0: local node Y coordinate, 4 bits.
- `noc_clk` in 1: the only clock; all logic on the rising edge.
- `noc_rst` in 1: reset, synchronous and active-high.
- `cmd_valid` in 1: a packet request is offered.
- `cmd_ready` out 1: the request is accepted this cycle when both are high.
- `cmd_dest_x` in 4: destination X.
- `cmd_dest_y` in 4: destination Y.
- `cmd_len` in 4: number of body flits, 0..15.
- `data_valid` in 1: a payload word is offered.
- `data_ready` out 1: the payload word is consumed when both are high.
- `data` in DATA_WIDTH: payload word.
- `flit_valid` out 1: the output flit is valid.
- `flit_ready` in 1: the fabric accepts the flit. A transfer ("fire") is `flit_valid & flit_ready`.
- `flit` out DATA_WIDTH: output flit.
- `VCready` in 1: the downstream virtual channel can take a new packet. Gates header issue only.
- `is_header` out 1: the current flit is the header.
- `is_tail` out 1: the current flit is the last flit of the packet.

## Operation
- **Header layout**, MSB first:
  - `[W-1:W-4]` dest_x
  - `[W-5:W-8]` dest_y
  - `[W-9:W-12]` SRC_X
  - `[W-13:W-16]` SRC_Y
  - `[W-17:W-20]` len
  - remaining low bits 0.
- **Output stage**: a single register holding `flit`, `is_header`, `is_tail` and `flit_valid`.
  - The stage may load when it is empty or firing this cycle.
  - While `flit_valid=1` and `flit_ready=0`, all outputs hold stable.
- **FSM states**: IDLE, HEAD, BODY. A 4-bit body counter `cnt` and latched `len`/`dest` registers support it.
- **IDLE**:
  - `cmd_ready=1`.
  - On cmd fire: latch `dest`/`len`, clear `cnt`, go to HEAD.
- **HEAD**:
  - When `VCready=1` and the stage can load, load the header with `is_header=1`.
  - `is_tail=1` iff `len==0` (without CRC).
  - When the header fires: if it was the tail, go to IDLE; otherwise go to BODY.
  - If `VCready` drops after the header is loaded, the valid header stays held. VCready is not re-checked.
- **BODY**:
  - `data_ready = (!flit_valid | flit_ready)`.
  - On data fire: load `data`, set `is_header=0`, set `is_tail = (cnt==len-1)`, increment `cnt`.
  - After the tail flit is loaded, `data_ready=0`.
  - When the tail fires, go to IDLE.
- `cmd_ready=0` and `data_ready=0` in every state other than the one named above.
- A packet of L body flits produces exactly L+1 flits, with exactly one `is_header` and exactly one `is_tail`.

## Timing
- **Reset**: while `noc_rst=1` on a clock edge, the next state is IDLE and the output register is cleared. During reset, `cmd_ready` and `data_ready` are 0.
- **Reset values**: `flit_valid=0`, `flit=0`, `is_header=0`, `is_tail=0`, `cmd_ready=0`, `data_ready=0`.
- **Reset mid-packet**: the packet is abandoned and `flit_valid` is 0 from the next cycle. Resending or recovering the partial packet downstream is not this block's job.
- **Header latency**: cmd fires at cycle T. HEAD is entered at T+1. With `VCready=1`, the header is valid at T+2.
- **Body latency**: a data fire at cycle T gives a valid flit at T+1.
- **Throughput**: 1 flit per cycle in BODY while `flit_ready` and `data_valid` are held high.
- **Tail to next header**: the tail fires at T. The block is IDLE at T+1, with `cmd_ready=1` at T+1. The next header is valid at T+3 at the earliest.
- **Simultaneous events**: a fire and a reload in the same cycle keep `flit_valid=1` with no bubble.

## Configuration
- `NOC_PKT_CRC_EN` defined:
  - After the last body flit (or directly after the header when `len==0`), append one checksum flit.
  - The checksum is the XOR of the header and all body flits.
  - The checksum flit alone carries `is_tail=1`; body flits never do.
  - Packet length is L+2 flits.
  - The FSM gains a CSUM state between BODY/HEAD and IDLE.
  - The header `len` field still encodes L.
- `NOC_PKT_CRC_EN` undefined: no checksum register and no CSUM state. Behaviour is as in Operation.

## Test plan
- **Reset**: hold `noc_rst=1` for 3 cycles with `cmd_valid=1` -> all outputs 0 and no cmd accepted. `cmd_ready=1` on the first cycle after reset.
- **Basic packet**: dest (2,3), len=3, `SRC_X=1`, `SRC_Y=0`, `VCready=1`, `flit_ready=1`, data 0xA, 0xB, 0xC ->
  - flits are 0x2310_3000, 0xA, 0xB, 0xC, back-to-back;
  - header has `is_header=1`, 0xC has `is_tail=1`;
  - header is valid 2 cycles after the cmd fire.
- **Zero length**: len=0 -> a single flit with `is_header=1` and `is_tail=1`, then IDLE.
- **VCready gating**: `VCready=0` for 5 cycles after the cmd -> `flit_valid` stays 0 and then rises the cycle after `VCready=1`. Dropping `VCready` while the header is pending does not retract it.
- **Backpressure**: toggle `flit_ready` 1,0,0,1,… on a len=4 packet -> `flit`/`is_tail` are stable while stalled, no flit is duplicated or lost, and `data_ready=0` during stalls.
- **With `NOC_PKT_CRC_EN`**: the len=3 packet above -> a 5th flit equal to 0x2310_3000^0xA^0xB^0xC is the only flit with `is_tail=1`.
